// File: rtl/pcm_spk_sequencer.sv
// PCM speaker playback sequencer: one-deep sample holding register feeding a
// bclk/lrclk/dataout serialiser that sends each mono sample in both slots.
module pcm_spk_sequencer #(
    parameter int CLK_DIV  = 2,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                dataout,
    output logic                done,
    output logic                underrun,
    output logic                busy
);

    // Slot indexing assumes SAMPLE_W is a power of two, so bit_cnt splits into
    // {lr, slot_bit}.
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
    localparam int BIT_W  = SLOT_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(2 * SAMPLE_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_MSB = SLOT_W'(SAMPLE_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                dataout_q, dataout_d;
    logic                done_q, done_d;
    logic                underrun_q, underrun_d;
    logic                sample_ready_q, sample_ready_d;

    logic                xfer;
    logic                frame_start;
    logic [SLOT_W-1:0]   slot_idx;

    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        bclk_d         = bclk_q;
        lrclk_d        = lrclk_q;
        dataout_d      = dataout_q;
        done_d         = 1'b0;
        underrun_d     = 1'b0;
        frame_start    = 1'b0;
        slot_idx       = '0;
        xfer           = sample_valid & sample_ready_q;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                dataout_d = 1'b0;
                // No start-up underrun: wait for a real sample before running.
                if (enable && hold_full_q) begin
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bclk_d    = ~bclk_q;
                    if (bclk_q) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            done_d = 1'b1;
                            if (enable) begin
                                frame_start = 1'b1;
                            end else begin
                                state_d   = IDLE;
                                bit_cnt_d = '0;
                                bclk_d    = 1'b0;
                                lrclk_d   = 1'b0;
                                dataout_d = 1'b0;
                            end
                        end else begin
                            // Data changes on the bclk fall so it is stable at the next rise.
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            slot_idx  = SLOT_MSB - bit_cnt_d[SLOT_W-1:0];
                            lrclk_d   = bit_cnt_d[SLOT_W];
                            dataout_d = shreg_q[slot_idx];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase

        if (frame_start) begin
            state_d   = RUN;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            if (hold_full_q) begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shreg_d    = '0;
                underrun_d = 1'b1;
            end
            dataout_d = shreg_d[SAMPLE_W-1];
        end

        // A sample arriving on a frame-start edge lands in hold, not shreg.
        if (xfer) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        sample_ready_d = enable & ~hold_full_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            bclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            dataout_q      <= 1'b0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            sample_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            bclk_q         <= bclk_d;
            lrclk_q        <= lrclk_d;
            dataout_q      <= dataout_d;
            done_q         <= done_d;
            underrun_q     <= underrun_d;
            sample_ready_q <= sample_ready_d;
        end
    end

    assign sample_ready = sample_ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign dataout      = dataout_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q == RUN);

endmodule
